// File: rtl/tea_pkg.sv
// Shared constants and encodings for the iterative TEA/XTEA engine.
// The XTEA option is selected by TEA_XTEA_EN; the algo encoding is always present.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9e3779b9;

    typedef enum logic {
        MODE_CIPHER   = 1'b0,
        MODE_DECIPHER = 1'b1
    } mode_e;

    typedef enum logic {
        ALGO_TEA  = 1'b0,
        ALGO_XTEA = 1'b1
    } algo_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tea_engine_iter_if.sv
// Request/response bundle between the key/data source, the engine and the consumer.
// iAlgo exists only when TEA_XTEA_EN is defined.
interface tea_engine_iter_if #(
    parameter int WORD_SIZE    = 32,
    parameter int ROUND_NUMBER = 32
);
    localparam int CW = $clog2(ROUND_NUMBER + 1);

    logic                 iValid;
    logic                 oReady;
    logic                 iMode;
`ifdef TEA_XTEA_EN
    logic                 iAlgo;
`endif
    logic [WORD_SIZE-1:0] iV0;
    logic [WORD_SIZE-1:0] iV1;
    logic [WORD_SIZE-1:0] iK0;
    logic [WORD_SIZE-1:0] iK1;
    logic [WORD_SIZE-1:0] iK2;
    logic [WORD_SIZE-1:0] iK3;
    logic                 oValid;
    logic                 iReady;
    logic [WORD_SIZE-1:0] oV0;
    logic [WORD_SIZE-1:0] oV1;
    logic                 oBusy;
    logic [CW-1:0]        oRoundCount;

    modport master (
`ifdef TEA_XTEA_EN
        output iAlgo,
`endif
        output iValid, iMode, iV0, iV1, iK0, iK1, iK2, iK3, iReady,
        input  oReady, oValid, oV0, oV1, oBusy, oRoundCount
    );

    modport slave (
`ifdef TEA_XTEA_EN
        input  iAlgo,
`endif
        input  iValid, iMode, iV0, iV1, iK0, iK1, iK2, iK3, iReady,
        output oReady, oValid, oV0, oV1, oBusy, oRoundCount
    );

endinterface

// File: rtl/tea_round.sv
// One combinational TEA round (cipher or decipher); with TEA_XTEA_EN it also
// implements the XTEA round, selected by algo_i.
module tea_round
    import tea_pkg::*;
#(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] DELTA_W   = WORD_SIZE'(TEA_DELTA)
) (
    input  logic [WORD_SIZE-1:0] v0_i,
    input  logic [WORD_SIZE-1:0] v1_i,
    input  logic [WORD_SIZE-1:0] sum_i,
    input  logic [WORD_SIZE-1:0] k0_i,
    input  logic [WORD_SIZE-1:0] k1_i,
    input  logic [WORD_SIZE-1:0] k2_i,
    input  logic [WORD_SIZE-1:0] k3_i,
    input  logic                 mode_i,
`ifdef TEA_XTEA_EN
    input  logic                 algo_i,
`endif
    output logic [WORD_SIZE-1:0] v0_o,
    output logic [WORD_SIZE-1:0] v1_o,
    output logic [WORD_SIZE-1:0] sum_o
);

    typedef logic [WORD_SIZE-1:0] word_t;

    function automatic word_t tea_f(word_t v, word_t s, word_t ka, word_t kb);
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    word_t sum_inc;
    word_t sum_dec;
    word_t v0_t;
    word_t v1_t;

    assign sum_inc = sum_i + DELTA_W;
    assign sum_dec = sum_i - DELTA_W;

`ifdef TEA_XTEA_EN
    function automatic word_t xtea_f(word_t v, word_t s, word_t k);
        return (((v << 4) ^ (v >> 5)) + v) ^ (s + k);
    endfunction

    word_t keys [4];
    assign keys = '{k0_i, k1_i, k2_i, k3_i};
`endif

    always_comb begin
        v0_t  = v0_i;
        v1_t  = v1_i;
        sum_o = sum_i;
`ifdef TEA_XTEA_EN
        if (algo_i == ALGO_XTEA) begin
            // Decipher runs the cipher steps backwards, so it starts from sum+DELTA.
            if (mode_i == MODE_DECIPHER) begin
                v1_t  = v1_i - xtea_f(v0_i, sum_i, keys[sum_i[12:11]]);
                v0_t  = v0_i - xtea_f(v1_t, sum_dec, keys[sum_dec[1:0]]);
                sum_o = sum_dec;
            end else begin
                v0_t  = v0_i + xtea_f(v1_i, sum_i, keys[sum_i[1:0]]);
                v1_t  = v1_i + xtea_f(v0_t, sum_inc, keys[sum_inc[12:11]]);
                sum_o = sum_inc;
            end
        end else
`endif
        if (mode_i == MODE_DECIPHER) begin
            v1_t  = v1_i - tea_f(v0_i, sum_i, k2_i, k3_i);
            v0_t  = v0_i - tea_f(v1_t, sum_i, k0_i, k1_i);
            sum_o = sum_dec;
        end else begin
            v0_t  = v0_i + tea_f(v1_i, sum_inc, k0_i, k1_i);
            v1_t  = v1_i + tea_f(v0_t, sum_inc, k2_i, k3_i);
            sum_o = sum_inc;
        end
    end

    assign v0_o = v0_t;
    assign v1_o = v1_t;

endmodule

// File: rtl/tea_engine_iter.sv
// Iterative TEA engine: one shared datapath for cipher/decipher, ROUNDS_PER_CYCLE
// rounds per clock. Define TEA_XTEA_EN to add the iAlgo input and XTEA rounds.
//
// state | meaning
// IDLE  | ready for a request; latches block, keys, mode on iValid
// RUN   | applying rounds, oRoundCount advancing
// DONE  | result on oV0/oV1 with oValid, waiting for iReady
module tea_engine_iter
    import tea_pkg::*;
#(
    parameter int          WORD_SIZE        = 32,
    parameter logic [31:0] DELTA            = TEA_DELTA,
    parameter int          ROUND_NUMBER     = 32,
    parameter int          ROUNDS_PER_CYCLE = 1
) (
    input logic               clk,
    input logic               rst,
    tea_engine_iter_if.slave  bus
);

    localparam int CW = $clog2(ROUND_NUMBER + 1);
    typedef logic [WORD_SIZE-1:0] word_t;
    localparam word_t DELTA_W = WORD_SIZE'(DELTA);
    localparam word_t DEC_SUM = WORD_SIZE'(DELTA_W * word_t'(ROUND_NUMBER));

    if ((ROUNDS_PER_CYCLE < 1) || ((ROUND_NUMBER % ROUNDS_PER_CYCLE) != 0)) begin : g_bad_cfg
        $error("tea_engine_iter: ROUNDS_PER_CYCLE must divide ROUND_NUMBER");
    end

    state_e                      state_q, state_d;
    word_t                       v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
    word_t                       res0_q, res0_d, res1_q, res1_d;
    logic [3:0][WORD_SIZE-1:0]   key_q, key_d;
    logic                        mode_q, mode_d;
    logic [CW-1:0]               cnt_q, cnt_d, cnt_next;
`ifdef TEA_XTEA_EN
    logic                        algo_q, algo_d;
`endif

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        word_t v0_in, v1_in, sum_in, v0_n, v1_n, sum_n;
        if (g == 0) begin : g_first
            assign v0_in  = v0_q;
            assign v1_in  = v1_q;
            assign sum_in = sum_q;
        end else begin : g_next
            assign v0_in  = g_round[g-1].v0_n;
            assign v1_in  = g_round[g-1].v1_n;
            assign sum_in = g_round[g-1].sum_n;
        end
        tea_round #(
            .WORD_SIZE (WORD_SIZE),
            .DELTA_W   (DELTA_W)
        ) u_round (
            .v0_i   (v0_in),
            .v1_i   (v1_in),
            .sum_i  (sum_in),
            .k0_i   (key_q[0]),
            .k1_i   (key_q[1]),
            .k2_i   (key_q[2]),
            .k3_i   (key_q[3]),
            .mode_i (mode_q),
`ifdef TEA_XTEA_EN
            .algo_i (algo_q),
`endif
            .v0_o   (v0_n),
            .v1_o   (v1_n),
            .sum_o  (sum_n)
        );
    end

    word_t v0_last, v1_last, sum_last;
    assign v0_last  = g_round[ROUNDS_PER_CYCLE-1].v0_n;
    assign v1_last  = g_round[ROUNDS_PER_CYCLE-1].v1_n;
    assign sum_last = g_round[ROUNDS_PER_CYCLE-1].sum_n;
    assign cnt_next = cnt_q + CW'(ROUNDS_PER_CYCLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            mode_q  <= MODE_CIPHER;
            cnt_q   <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
`ifdef TEA_XTEA_EN
            algo_q  <= ALGO_TEA;
`endif
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
`ifdef TEA_XTEA_EN
            algo_q  <= algo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        sum_d   = sum_q;
        key_d   = key_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
`ifdef TEA_XTEA_EN
        algo_d  = algo_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.iValid) begin
                    v0_d    = bus.iV0;
                    v1_d    = bus.iV1;
                    key_d   = {bus.iK3, bus.iK2, bus.iK1, bus.iK0};
                    mode_d  = bus.iMode;
                    sum_d   = (bus.iMode == MODE_DECIPHER) ? DEC_SUM : '0;
                    cnt_d   = '0;
`ifdef TEA_XTEA_EN
                    algo_d  = bus.iAlgo;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                v0_d  = v0_last;
                v1_d  = v1_last;
                sum_d = sum_last;
                cnt_d = cnt_next;
                // Results become visible only once the last round has been applied.
                if (cnt_next == CW'(ROUND_NUMBER)) begin
                    res0_d  = v0_last;
                    res1_d  = v1_last;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.iReady) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.oReady      = (state_q == IDLE);
    assign bus.oBusy       = (state_q == RUN);
    assign bus.oValid      = (state_q == DONE);
    assign bus.oRoundCount = cnt_q;
    assign bus.oV0         = res0_q;
    assign bus.oV1         = res1_q;

endmodule

// File: tb/tb_tea_engine_iter.sv
// Bench for tea_engine_iter: one-round-per-clock and four-round-per-clock cores
// share stimulus; known TEA/XTEA vectors, round trips, backpressure, mid-run reset.
module tb_tea_engine_iter;
    import tea_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tea_engine_iter_if #(.WORD_SIZE(32), .ROUND_NUMBER(32)) bus1 ();
    tea_engine_iter_if #(.WORD_SIZE(32), .ROUND_NUMBER(32)) bus4 ();

    assign bus4.iValid = bus1.iValid;
    assign bus4.iMode  = bus1.iMode;
    assign bus4.iV0    = bus1.iV0;
    assign bus4.iV1    = bus1.iV1;
    assign bus4.iK0    = bus1.iK0;
    assign bus4.iK1    = bus1.iK1;
    assign bus4.iK2    = bus1.iK2;
    assign bus4.iK3    = bus1.iK3;
    assign bus4.iReady = bus1.iReady;
`ifdef TEA_XTEA_EN
    logic cur_algo = 1'b0;
    assign bus4.iAlgo  = bus1.iAlgo;
`endif

    tea_engine_iter #(
        .WORD_SIZE(32), .DELTA(32'h9e3779b9), .ROUND_NUMBER(32), .ROUNDS_PER_CYCLE(1)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    tea_engine_iter #(
        .WORD_SIZE(32), .DELTA(32'h9e3779b9), .ROUND_NUMBER(32), .ROUNDS_PER_CYCLE(4)
    ) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "/flags1"}, 64'({bus1.oReady, bus1.oValid, bus1.oBusy, bus1.oRoundCount}), 64'(9'b100_000000));
        check_eq({tag, "/data1"},  {bus1.oV0, bus1.oV1}, 64'd0);
        check_eq({tag, "/flags4"}, 64'({bus4.oReady, bus4.oValid, bus4.oBusy, bus4.oRoundCount}), 64'(9'b100_000000));
        check_eq({tag, "/data4"},  {bus4.oV0, bus4.oV1}, 64'd0);
    endtask

    task automatic run_block(input string tag, input logic mode,
                             input logic [31:0] v0, v1, k0, k1, k2, k3,
                             input bit hold_valid, input int bp,
                             output logic [31:0] r1_0, r1_1, r4_0, r4_1);
        int  cyc, l1, l4;
        bit  ready_low, busy_ok, stable;
        @(negedge clk);
        check_eq({tag, "/ready_in"}, 64'(bus1.oReady & bus4.oReady), 1);
        bus1.iValid = 1'b1;
        bus1.iMode  = mode;
`ifdef TEA_XTEA_EN
        bus1.iAlgo  = cur_algo;
`endif
        bus1.iV0 = v0; bus1.iV1 = v1;
        bus1.iK0 = k0; bus1.iK1 = k1; bus1.iK2 = k2; bus1.iK3 = k3;
        @(posedge clk); #1;
        cyc = 1; l1 = 0; l4 = 0;
        ready_low = 1'b1; busy_ok = 1'b1;
        if (hold_valid) begin
            bus1.iV0 = ~v0; bus1.iV1 = v1 ^ 32'h5a5a5a5a;
            bus1.iK0 = k0 + 32'd1; bus1.iK3 = ~k3; bus1.iMode = ~mode;
        end else begin
            bus1.iValid = 1'b0;
        end
        while ((l1 == 0 || l4 == 0) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus1.oValid && l1 == 0) l1 = cyc;
            if (bus4.oValid && l4 == 0) l4 = cyc;
            if (l1 == 0 && !bus1.oBusy) busy_ok = 1'b0;
            if (bus1.oReady || bus4.oReady) ready_low = 1'b0;
        end
        check_eq({tag, "/not_ready"}, 64'(ready_low), 1);
        check_eq({tag, "/busy"}, 64'(busy_ok), 1);
        check_eq({tag, "/lat1"}, 64'(l1), 33);
        check_eq({tag, "/lat4"}, 64'(l4), 9);
        bus1.iValid = 1'b0;
        r1_0 = bus1.oV0; r1_1 = bus1.oV1;
        r4_0 = bus4.oV0; r4_1 = bus4.oV1;
        stable = 1'b1;
        repeat (bp) begin
            @(posedge clk); #1;
            if (!bus1.oValid || !bus4.oValid || bus1.oV0 !== r1_0 || bus1.oV1 !== r1_1 ||
                bus4.oV0 !== r4_0 || bus4.oV1 !== r4_1 || bus1.oReady) stable = 1'b0;
        end
        if (bp > 0) check_eq({tag, "/bp_stable"}, 64'(stable), 1);
        @(negedge clk);
        bus1.iReady = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "/handoff"},
                 64'({bus1.oReady, bus1.oValid, bus1.oRoundCount, bus4.oReady, bus4.oValid, bus4.oRoundCount}),
                 64'(16'b10_000000_10_000000));
        bus1.iReady = 1'b0;
    endtask

    logic [31:0] a0, a1, b0, b1, d0, d1, e0, e1;
    logic [31:0] rv0, rv1, rk0, rk1, rk2, rk3;
    int          cyc;

    initial begin
        rst = 1'b1;
        bus1.iValid = 1'b0; bus1.iReady = 1'b0; bus1.iMode = 1'b0;
        bus1.iV0 = '0; bus1.iV1 = '0;
        bus1.iK0 = '0; bus1.iK1 = '0; bus1.iK2 = '0; bus1.iK3 = '0;
`ifdef TEA_XTEA_EN
        bus1.iAlgo = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero key, zero block, with 20 cycles of backpressure in DONE.
        run_block("enc0", MODE_CIPHER, 0, 0, 0, 0, 0, 0, 1'b0, 20, a0, a1, b0, b1);
        check_eq("enc0/res1", {a0, a1}, 64'h41ea3a0a_94baa940);
        check_eq("enc0/res4", {b0, b1}, 64'h41ea3a0a_94baa940);

        // Reset in the middle of a cipher, at round 10 of the single-round core.
        @(negedge clk);
        bus1.iValid = 1'b1; bus1.iMode = MODE_CIPHER;
        bus1.iV0 = 32'h12345678; bus1.iV1 = 32'h9abcdef0;
        @(posedge clk); #1;
        bus1.iValid = 1'b0;
        cyc = 0;
        while (bus1.oRoundCount != 6'd10 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("mid/count1", 64'(bus1.oRoundCount), 10);
        check_eq("mid/busy1", 64'({bus1.oBusy, bus1.oValid}), 64'(2'b10));
        check_eq("mid/hold1", {bus1.oV0, bus1.oV1}, 64'h41ea3a0a_94baa940);
        check_eq("mid/done4", 64'({bus4.oValid, bus4.oRoundCount}), 64'(7'b1_100000));
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("mid_rst");
        rst = 1'b0;
        bus1.iV0 = '0; bus1.iV1 = '0;

        run_block("enc0b", MODE_CIPHER, 0, 0, 0, 0, 0, 0, 1'b0, 0, a0, a1, b0, b1);
        check_eq("enc0b/res1", {a0, a1}, 64'h41ea3a0a_94baa940);
        check_eq("enc0b/res4", {b0, b1}, 64'h41ea3a0a_94baa940);

        run_block("dec0", MODE_DECIPHER, 32'h41ea3a0a, 32'h94baa940, 0, 0, 0, 0, 1'b0, 0, a0, a1, b0, b1);
        check_eq("dec0/res1", {a0, a1}, 64'd0);
        check_eq("dec0/res4", {b0, b1}, 64'd0);

        // Random round trips with iValid held high while the cores are busy.
        for (int i = 0; i < 100; i++) begin
            rv0 = $urandom; rv1 = $urandom;
            rk0 = $urandom; rk1 = $urandom; rk2 = $urandom; rk3 = $urandom;
            run_block($sformatf("rt%0d/enc", i), MODE_CIPHER, rv0, rv1, rk0, rk1, rk2, rk3,
                      1'b1, 0, a0, a1, b0, b1);
            check_eq($sformatf("rt%0d/enc_match", i), {b0, b1}, {a0, a1});
            run_block($sformatf("rt%0d/dec", i), MODE_DECIPHER, a0, a1, rk0, rk1, rk2, rk3,
                      1'b1, 0, d0, d1, e0, e1);
            check_eq($sformatf("rt%0d/back1", i), {d0, d1}, {rv0, rv1});
            check_eq($sformatf("rt%0d/back4", i), {e0, e1}, {rv0, rv1});
        end

`ifdef TEA_XTEA_EN
        cur_algo = 1'b1;
        run_block("xenc0", MODE_CIPHER, 0, 0, 0, 0, 0, 0, 1'b0, 0, a0, a1, b0, b1);
        check_eq("xenc0/res1", {a0, a1}, 64'hdee9d4d8_f7131ed9);
        check_eq("xenc0/res4", {b0, b1}, 64'hdee9d4d8_f7131ed9);
        run_block("xdec0", MODE_DECIPHER, 32'hdee9d4d8, 32'hf7131ed9, 0, 0, 0, 0, 1'b0, 0, a0, a1, b0, b1);
        check_eq("xdec0/res1", {a0, a1}, 64'd0);
        check_eq("xdec0/res4", {b0, b1}, 64'd0);
        cur_algo = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tea_engine_iter.md
Name: tea_engine_iter

Overview:
- Next-generation TEA block: a single iterative core performs both cipher and decipher, selected per request by a mode bit.
- Replaces the separate cipher/decipher paths with one datapath, a valid/ready handshake on input and output, and a configurable number of rounds unrolled per clock.
- Sits between the key/data source and the downstream consumer in the crypto subsystem.

Parameters:
- WORD_SIZE, 32, width of each half-block, each key word and the sum register.
- DELTA, 32'h9e3779b9, key-schedule constant, truncated or zero-extended to WORD_SIZE.
- ROUND_NUMBER, 32, number of TEA cycles per block.
- ROUNDS_PER_CYCLE, 1, rounds computed per clock. Must divide ROUND_NUMBER; the design raises an elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- iValid  in  1  request valid.
- oReady  out  1  core can accept a request.
- iMode  in  1  0 = cipher, 1 = decipher.
- iV0, iV1  in  WORD_SIZE  input half-blocks.
- iK0, iK1, iK2, iK3  in  WORD_SIZE  key words.
- oValid  out  1  result valid.
- iReady  in  1  consumer accepts result.
- oV0, oV1  out  WORD_SIZE  result half-blocks.
- oBusy  out  1  high in RUN.
- oRoundCount  out  $clog2(ROUND_NUMBER+1)  rounds completed on the current block.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, oReady=1, oValid=0, oBusy=0, oRoundCount=0, oV0=oV1=0, sum=0, latched keys=0.
- States:
  - IDLE: oReady=1. On iValid&oReady, latch iV0, iV1, keys and mode, go to RUN. Initial sum is 0 for cipher; for decipher it is DELTA*ROUND_NUMBER mod 2^WORD_SIZE, a constant computed at elaboration.
  - RUN: each clock applies ROUNDS_PER_CYCLE rounds and adds ROUNDS_PER_CYCLE to oRoundCount. When the count reaches ROUND_NUMBER, go to DONE.
  - DONE: oValid=1 and oV0/oV1 hold the result. On iReady, go to IDLE with oValid=0 and oRoundCount=0.
- Cipher round, all arithmetic mod 2^WORD_SIZE:
  - sum += DELTA
  - v0 += ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)
  - v1 += ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3), using the updated v0
- Decipher round:
  - v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
  - v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1), using the updated v1
  - sum -= DELTA
- Shifts are logical; wrap-around is silent.
- Latency from accept to oValid is exactly ROUND_NUMBER/ROUNDS_PER_CYCLE + 1 clocks.
- Throughput:
  - oReady is low in RUN and DONE, so iValid is ignored there.
  - No new request is accepted in the same cycle that DONE hands off. Re-accept happens at the earliest in the following IDLE cycle.
- Input changes after accept have no effect; keys and mode are latched.
- Backpressure: while iReady=0, DONE holds indefinitely with stable outputs.
- rst asserted in any state, including mid-RUN, forces the reset values on the next edge. A partial result never appears on oV0/oV1.
- oV0/oV1 update only on the transition into DONE.

Optional Feature:
- Macro TEA_XTEA_EN.
- When defined:
  - Adds input iAlgo (1 bit; 0 = TEA, 1 = XTEA), latched at accept.
  - XTEA cipher: v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum+k[sum&3]); then sum += DELTA; then v1 += (((v0<<4)^(v0>>5))+v0) ^ (sum+k[(sum>>11)&3]).
  - XTEA decipher is the exact inverse of the cipher.
  - Latency is identical to TEA.
- When undefined: the iAlgo port is absent and the core is TEA-only.

Decomposition:
- Package tea_pkg holds:
  - default DELTA;
  - the mode encoding (MODE_CIPHER=0, MODE_DECIPHER=1);
  - the algo encoding (ALGO_TEA=0, ALGO_XTEA=1);
  - the FSM state encoding (IDLE, RUN, DONE).
- Sub-module tea_round: combinational single round taking v0, v1, sum, keys, mode (and algo under the macro), producing next v0, v1, sum.
- tea_engine_iter instantiates ROUNDS_PER_CYCLE copies of tea_round chained in a generate loop.

Test Plan:
- Cipher with all-zero key, v0=v1=0, ROUND_NUMBER=32 -> oV0=32'h41ea3a0a, oV1=32'h94baa940 after 33 clocks.
- Decipher of 41ea3a0a/94baa940 with zero key -> oV0=oV1=0. Repeat with ROUNDS_PER_CYCLE=4 -> same result with oValid 9 clocks after accept.
- Round-trip with random keys and blocks (100 iterations): cipher then decipher returns the original block. iValid is asserted during RUN and must be ignored (oReady=0).
- Hold iReady=0 for 20 clocks in DONE -> oValid and oV0/oV1 stable. Release iReady -> oReady=1 on the next clock.
- Assert rst at round 10 of a cipher -> next cycle all outputs at reset values. A fresh zero-key request then still yields 41ea3a0a/94baa940.
- With TEA_XTEA_EN defined: XTEA cipher of zero key and zero block -> oV0=32'hdee9d4d8, oV1=32'hf7131ed9. Deciphering that result returns zeros.
